// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer logic. The write side
// uses them now and the read side will reuse them later.
package fifo_pkg;

  // Pointer width for a given address width. The extra MSB tells a full
  // FIFO apart from an empty one when the address bits are equal.
  function automatic int calc_pw(input int addr_width);
    return addr_width + 1;
  endfunction

  // Number of storage slots for a given address width.
  function automatic int calc_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Default pointer type, sized for the standard 32-entry FIFO.
  localparam int PW_DEFAULT = calc_pw(5);

  typedef logic [PW_DEFAULT-1:0] ptr_t;

  // In gray code, a write pointer exactly one lap ahead of the read pointer
  // matches the read pointer with its two MSBs inverted.
  function automatic ptr_t full_cmp_pattern(input ptr_t p);
    return {~p[PW_DEFAULT-1:PW_DEFAULT-2], p[PW_DEFAULT-3:0]};
  endfunction

endpackage

// File: rtl/b2g_converter.sv
// Binary to gray converter, combinational. Each bit is the XOR of itself
// and the next higher binary bit.
module b2g_converter #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/g2b_converter.sv
// Gray to binary converter, combinational. Each binary bit is the XOR of
// all gray bits from the MSB down to that position. Shared by both FIFO
// sides.
module g2b_converter #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin[WIDTH-1] = gray[WIDTH-1];

  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_prefix
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/fifo_wr_ptr_full.sv
// Write-side pointer and flag stage of the dual-clock FIFO. It keeps the
// binary and gray write pointers, synchronises the read pointer into the
// write clock domain, and produces full, almost_full, the fill level and
// the overflow pulse. Full is pessimistic: a remote read takes three edges
// to lower it, so occupancy is never under-reported.
module fifo_wr_ptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int AF_MARGIN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [calc_pw(ADDR_WIDTH)-1:0] rd_gray_ptr,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic                          wr_accept,
  output logic [calc_pw(ADDR_WIDTH)-1:0] wr_gray_ptr,
  output logic                          full,
  output logic                          almost_full,
  output logic [calc_pw(ADDR_WIDTH)-1:0] wr_level,
  output logic                          wr_overflow
);

  localparam int LPW    = calc_pw(ADDR_WIDTH);
  localparam int LDEPTH = calc_depth(ADDR_WIDTH);

  localparam logic [LPW-1:0] AF_LEVEL = LPW'(LDEPTH - AF_MARGIN);

  logic [LPW-1:0] wr_bin;
  logic [LPW-1:0] wr_bin_next;
  logic [LPW-1:0] wr_gray_next;
  logic [LPW-1:0] rq1;
  logic [LPW-1:0] rq2;
  logic [LPW-1:0] rd_bin_sync;
  logic [LPW-1:0] full_pattern;
  logic [LPW-1:0] level_next;
  logic           full_next;
  logic           almost_full_next;

  // Writes are refused while full, so the RAM and the pointer stay intact.
  assign wr_accept   = wr_en & ~full;
  assign wr_addr     = wr_bin[ADDR_WIDTH-1:0];
  assign wr_bin_next = wr_bin + LPW'(wr_accept);

  b2g_converter #(
    .WIDTH(LPW)
  ) u_b2g (
    .bin (wr_bin_next),
    .gray(wr_gray_next)
  );

  g2b_converter #(
    .WIDTH(LPW)
  ) u_g2b (
    .gray(rq2),
    .bin (rd_bin_sync)
  );

  // The shared helper is sized for the default pointer width; other
  // widths build the same pattern in place.
  if (LPW == PW_DEFAULT) begin : g_pat_pkg
    assign full_pattern = full_cmp_pattern(rq2);
  end else begin : g_pat_local
    assign full_pattern = {~rq2[LPW-1:LPW-2], rq2[LPW-3:0]};
  end

  // Flags are computed from the next pointer so they line up with
  // wr_gray_ptr in the same cycle.
  assign full_next        = (wr_gray_next == full_pattern);
  assign level_next       = wr_bin_next - rd_bin_sync;
  assign almost_full_next = (level_next >= AF_LEVEL);

  // Pointer, synchroniser and flag registers, all reset together.
  // NOTE: non-blocking assignments let rq2 take the old rq1, forming two
  // real flops; blocking here would collapse the synchroniser into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bin      <= '0;
      wr_gray_ptr <= '0;
      rq1         <= '0;
      rq2         <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      wr_overflow <= 1'b0;
    end else begin
      rq1         <= rd_gray_ptr;
      rq2         <= rq1;
      wr_bin      <= wr_bin_next;
      wr_gray_ptr <= wr_gray_next;
      full        <= full_next;
      almost_full <= almost_full_next;
      wr_level    <= level_next;
      wr_overflow <= wr_en & full;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// Directed bench for fifo_wr_ptr_full with the default 32-entry geometry.
// Expected values are hand-derived; gray codes come from the bench's own
// b2g function.
module tb_fifo_wr_ptr_full;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [5:0] rd_gray_ptr;
  logic [4:0] wr_addr;
  logic       wr_accept;
  logic [5:0] wr_gray_ptr;
  logic       full;
  logic       almost_full;
  logic [5:0] wr_level;
  logic       wr_overflow;

  int errors = 0;
  int checks = 0;

  fifo_wr_ptr_full #(
    .ADDR_WIDTH(5),
    .AF_MARGIN (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_gray_ptr(rd_gray_ptr),
    .wr_addr    (wr_addr),
    .wr_accept  (wr_accept),
    .wr_gray_ptr(wr_gray_ptr),
    .full       (full),
    .almost_full(almost_full),
    .wr_level   (wr_level),
    .wr_overflow(wr_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] b2g(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] w;
  logic [5:0] prev_gray;

  initial begin
    rst         = 1'b1;
    wr_en       = 1'b1;
    rd_gray_ptr = '0;

    // 1: reset held two cycles with wr_en high
    tick();
    tick();
    check("rst_addr",  wr_addr, 0);
    check("rst_gray",  wr_gray_ptr, 0);
    check("rst_full",  full, 0);
    check("rst_af",    almost_full, 0);
    check("rst_level", wr_level, 0);
    check("rst_ovf",   wr_overflow, 0);

    // 2: fill all 32 slots with the reader parked at zero
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 27) check("af_low_27", almost_full, 0);
      if (i == 28) check("af_high_28", almost_full, 1);
      if (i == 31) check("full_low_31", full, 0);
    end
    check("fill_full",  full, 1);
    check("fill_level", wr_level, 32);
    check("fill_gray",  wr_gray_ptr, 6'b110000);
    check("fill_addr",  wr_addr, 0);
    check("fill_ovf",   wr_overflow, 0);
    check("fill_acc0",  wr_accept, 0);

    // 3: writes while full produce overflow pulses and no state change
    tick();
    check("ovf1",      wr_overflow, 1);
    check("ovf1_gray", wr_gray_ptr, 6'b110000);
    check("ovf1_acc",  wr_accept, 0);
    tick();
    check("ovf2",       wr_overflow, 1);
    check("ovf2_gray",  wr_gray_ptr, 6'b110000);
    check("ovf2_level", wr_level, 32);
    wr_en = 1'b0;
    tick();
    check("ovf_clear", wr_overflow, 0);

    // 4: one remote read reaches full/level on the third edge
    rd_gray_ptr = 6'b000001;
    tick();
    check("rd_e1_full",  full, 1);
    check("rd_e1_level", wr_level, 32);
    tick();
    check("rd_e2_full",  full, 1);
    check("rd_e2_level", wr_level, 32);
    tick();
    check("rd_e3_full",  full, 0);
    check("rd_e3_level", wr_level, 31);
    check("rd_e3_af",    almost_full, 1);

    // 5: 70 writes with the reader trailing by two, across the pointer wrap
    rst         = 1'b1;
    rd_gray_ptr = '0;
    tick();
    rst       = 1'b0;
    wr_en     = 1'b1;
    w         = '0;
    prev_gray = '0;
    for (int i = 1; i <= 70; i++) begin
      rd_gray_ptr = (i >= 3) ? b2g(w - 6'd2) : 6'd0;
      tick();
      w = w + 6'd1;
      check("wrap_gray", wr_gray_ptr, b2g(w));
      check("wrap_1bit", $countones(wr_gray_ptr ^ prev_gray), 1);
      check("wrap_full", full, 0);
      if (i >= 5) check("wrap_level", wr_level, 5);
      if (i == 63) check("wrap_g63", wr_gray_ptr, 6'b100000);
      if (i == 64) begin
        check("wrap_g64", wr_gray_ptr, 6'b000000);
        check("wrap_a64", wr_addr, 0);
      end
      prev_gray = wr_gray_ptr;
    end

    // 6: reset in the middle of a burst at level 17
    rst         = 1'b1;
    rd_gray_ptr = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    check("mid_level", wr_level, 17);
    check("mid_addr",  wr_addr, 17);
    rst = 1'b1;
    tick();
    check("mrst_addr",  wr_addr, 0);
    check("mrst_gray",  wr_gray_ptr, 0);
    check("mrst_full",  full, 0);
    check("mrst_af",    almost_full, 0);
    check("mrst_level", wr_level, 0);
    check("mrst_ovf",   wr_overflow, 0);
    rst = 1'b0;
    #1;
    check("resume_acc", wr_accept, 1);
    tick();
    check("resume_addr",  wr_addr, 1);
    check("resume_level", wr_level, 1);
    check("resume_gray",  wr_gray_ptr, 6'b000001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
